// File: rtl/byte_unstrip_n.sv
// byte_unstrip_n: lane-to-byte unstriper with valid/ready flow control on both sides.
// A multi-lane word is captured into holding registers in one handshake, then its
// surviving lanes are emitted one per output handshake, lowest lane index first.

module byte_unstrip_n #(
    parameter int unsigned        LANES    = 4,
    parameter int unsigned        DATA_W   = 8,
    parameter bit                 DROP_SKP = 1'b1,
    parameter logic [DATA_W-1:0]  SKP_CODE = 8'h1C
) (
    input  logic                      CLK,
    input  logic                      RESET_L,
    input  logic [LANES*DATA_W-1:0]   LANE_DATA,
    input  logic [LANES-1:0]          LANE_K,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [1:0]                WIDTH_SEL,
    output logic [DATA_W-1:0]         D,
    output logic                      DK,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY
);

    // Holding registers and pending-lane mask; this is the entire state.
    logic [LANES-1:0][DATA_W-1:0] h_data_q, h_data_d;
    logic [LANES-1:0]             h_k_q, h_k_d;
    logic [LANES-1:0]             pend_q, pend_d;

    logic [3:0]       act_raw;
    logic [3:0]       act_cnt;
    logic [LANES-1:0] new_pend;
    logic [LANES-1:0] lowest;
    logic             single;
    logic             in_hs;
    logic             out_hs;

    // Active lane count from WIDTH_SEL, clamped to the physical lane count.
    always_comb begin
        unique case (WIDTH_SEL)
            2'd0:    act_raw = 4'd1;
            2'd1:    act_raw = 4'd2;
            2'd2:    act_raw = 4'd4;
            default: act_raw = 4'd8;
        endcase
        act_cnt = (32'(act_raw) > LANES) ? LANES[3:0] : act_raw;
    end

    // Pending mask for an incoming word: active lanes that are not skip symbols.
    always_comb begin
        new_pend = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            new_pend[i] = (i < 32'(act_cnt)) &&
                          !(DROP_SKP && LANE_K[i] &&
                            (LANE_DATA[i*DATA_W +: DATA_W] == SKP_CODE));
        end
    end

    // Isolate the lowest pending lane; it is the one currently presented.
    always_comb begin
        lowest = pend_q & (~pend_q + LANES'(1));
        single = (pend_q != '0) && (pend_q == lowest);
    end

    // Outputs are a mux of registered state only; IN_READY also looks at OUT_READY
    // so the final pop and the next capture can share a cycle.
    always_comb begin
        D = '0;
        DK = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lowest[i]) begin
                D  = D | h_data_q[i];
                DK = DK | h_k_q[i];
            end
        end
        OUT_VALID = (pend_q != '0);
        IN_READY  = (pend_q == '0) || (OUT_READY && single);
    end

    assign in_hs  = IN_VALID && IN_READY;
    assign out_hs = OUT_VALID && OUT_READY;

    // Next state: a pop clears the lowest pending bit; a capture replaces the word.
    // A capture only happens when the mask is empty or its last bit is being popped,
    // so overwriting the mask after the pop is safe.
    always_comb begin
        pend_d   = pend_q;
        h_data_d = h_data_q;
        h_k_d    = h_k_q;
        if (out_hs) begin
            pend_d = pend_q & ~lowest;
        end
        if (in_hs) begin
            pend_d   = new_pend;
            h_data_d = LANE_DATA;
            h_k_d    = LANE_K;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            pend_q   <= '0;
            h_data_q <= '0;
            h_k_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            h_data_q <= h_data_d;
            h_k_q    <= h_k_d;
        end
    end

`ifndef SYNTHESIS
    // A stalled symbol must stay put until the consumer takes it.
    hold_under_backpressure: assert property (
        @(posedge CLK) disable iff (!RESET_L)
        (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(D) && $stable(DK))
    );

    // Accepting a word while symbols are pending is only legal on the final pop.
    no_overwrite_pending: assert property (
        @(posedge CLK) disable iff (!RESET_L)
        (IN_READY && OUT_VALID) |-> OUT_READY
    );
`endif

endmodule
